// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, delayed active-low syncs, active flag, blanked RGB.
// Optional macro VGA_TIMING_BORDER_EN forces a white one-pixel frame around the visible area.
module vga_timing_gen #(
    parameter int          TOTAL_COLS    = 800,
    parameter int          TOTAL_ROWS    = 525,
    parameter int          ACTIVE_COLS   = 640,
    parameter int          ACTIVE_ROWS   = 480,
    parameter int          H_FRONT_PORCH = 16,
    parameter int          H_BACK_PORCH  = 48,
    parameter int          V_FRONT_PORCH = 10,
    parameter int          V_BACK_PORCH  = 33,
    parameter int unsigned VIDEO_DELAY   = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] in_Red,
    input  logic [3:0] in_Green,
    input  logic [3:0] in_Blue,
    output logic [9:0] column_count,
    output logic [9:0] row_count,
    output logic       frame_start,
    output logic       out_Hsync,
    output logic       out_Vsync,
    output logic       out_active,
    output logic [3:0] out_Red,
    output logic [3:0] out_Green,
    output logic [3:0] out_Blue
);

    localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] HS_START = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] HS_END   = 10'(TOTAL_COLS - H_BACK_PORCH - 1);
    localparam logic [9:0] VS_START = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] VS_END   = 10'(TOTAL_ROWS - V_BACK_PORCH - 1);
    localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);

    // Delay-line word: [0] hsync, [1] vsync, [2] active, optionally [3] col edge, [4] row edge.
`ifdef VGA_TIMING_BORDER_EN
    localparam int W = 5;
    localparam logic [9:0] COL_EDGE = 10'(ACTIVE_COLS - 1);
    localparam logic [9:0] ROW_EDGE = 10'(ACTIVE_ROWS - 1);
`else
    localparam int W = 3;
`endif
    localparam logic [W-1:0] BUS_RST = W'(3'b011);

    logic         col_wrap;
    logic         row_wrap;
    logic         fs_q;
    logic [W-1:0] raw_bus;
    logic [W-1:0] tail_bus;

    assign col_wrap = (column_count == COL_LAST);
    assign row_wrap = (row_count == ROW_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            column_count <= '0;
            row_count    <= '0;
            fs_q         <= 1'b0;
        end else if (enable) begin
            fs_q <= col_wrap && row_wrap;
            if (col_wrap) begin
                column_count <= '0;
                row_count    <= row_wrap ? '0 : row_count + 10'd1;
            end else begin
                column_count <= column_count + 10'd1;
            end
        end
    end

    // The pulse register holds through stalls and is gated so it only shows on an enabled cycle.
    assign frame_start = fs_q && enable;

    always_comb begin
        raw_bus    = BUS_RST;
        raw_bus[0] = !((column_count >= HS_START) && (column_count <= HS_END));
        raw_bus[1] = !((row_count >= VS_START) && (row_count <= VS_END));
        raw_bus[2] = (column_count < ACT_COLS) && (row_count < ACT_ROWS);
`ifdef VGA_TIMING_BORDER_EN
        raw_bus[3] = (column_count == 10'd0) || (column_count == COL_EDGE);
        raw_bus[4] = (row_count == 10'd0) || (row_count == ROW_EDGE);
`endif
    end

    generate
        if (VIDEO_DELAY == 0) begin : g_nodelay
            assign tail_bus = raw_bus;
        end else begin : g_delay
            logic [W-1:0] stage [VIDEO_DELAY];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < VIDEO_DELAY; i++) begin
                        stage[i] <= BUS_RST;
                    end
                end else if (enable) begin
                    stage[0] <= raw_bus;
                    for (int unsigned i = 1; i < VIDEO_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign tail_bus = stage[VIDEO_DELAY-1];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_Hsync  <= 1'b1;
            out_Vsync  <= 1'b1;
            out_active <= 1'b0;
            out_Red    <= '0;
            out_Green  <= '0;
            out_Blue   <= '0;
        end else if (enable) begin
            out_Hsync  <= tail_bus[0];
            out_Vsync  <= tail_bus[1];
            out_active <= tail_bus[2];
            if (!tail_bus[2]) begin
                out_Red   <= '0;
                out_Green <= '0;
                out_Blue  <= '0;
`ifdef VGA_TIMING_BORDER_EN
            end else if (tail_bus[3] || tail_bus[4]) begin
                out_Red   <= '1;
                out_Green <= '1;
                out_Blue  <= '1;
`endif
            end else begin
                out_Red   <= in_Red;
                out_Green <= in_Green;
                out_Blue  <= in_Blue;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: reset, free-running lines/frames, stalls, mid-frame reset.
// Frame height is shortened to 12 lines so full frames fit in a short run.
module tb_vga_timing_gen;

    localparam int VD    = 2;
    localparam int TC    = 800;
    localparam int TR    = 12;
    localparam int FRAME = TC * TR;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] in_Red = '0;
    logic [3:0] in_Green = '0;
    logic [3:0] in_Blue = '0;
    logic [9:0] column_count;
    logic [9:0] row_count;
    logic       frame_start;
    logic       out_Hsync;
    logic       out_Vsync;
    logic       out_active;
    logic [3:0] out_Red;
    logic [3:0] out_Green;
    logic [3:0] out_Blue;

    int          checks = 0;
    int          failures = 0;
    int          k = 0;
    logic [15:0] lfsr = 16'hACE1;

    vga_timing_gen #(
        .TOTAL_COLS   (TC),
        .TOTAL_ROWS   (TR),
        .ACTIVE_COLS  (640),
        .ACTIVE_ROWS  (6),
        .H_FRONT_PORCH(16),
        .H_BACK_PORCH (48),
        .V_FRONT_PORCH(2),
        .V_BACK_PORCH (2),
        .VIDEO_DELAY  (VD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .in_Red      (in_Red),
        .in_Green    (in_Green),
        .in_Blue     (in_Blue),
        .column_count(column_count),
        .row_count   (row_count),
        .frame_start (frame_start),
        .out_Hsync   (out_Hsync),
        .out_Vsync   (out_Vsync),
        .out_active  (out_active),
        .out_Red     (out_Red),
        .out_Green   (out_Green),
        .out_Blue    (out_Blue)
    );

    always #5 clock = ~clock;

    // Colour driven while k enabled edges have elapsed.
    function automatic logic [3:0] rgb_r(input int n);
        return 4'(n);
    endfunction
    function automatic logic [3:0] rgb_g(input int n);
        return 4'(~n);
    endfunction
    function automatic logic [3:0] rgb_b(input int n);
        return 4'(n >> 4) ^ 4'hA;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d k=%0d", tag, obs, exp, k);
        end
    endtask

    // Output after m enabled edges shows position m-VD-1 with the colour driven before edge m.
    task automatic check_all();
        int p, pc, pr;
        logic ehs, evs, eact, efs;
        logic [3:0] er, eg, eb;
        ehs  = 1'b1;
        evs  = 1'b1;
        eact = 1'b0;
        er   = 4'h0;
        eg   = 4'h0;
        eb   = 4'h0;
        efs  = enable && (k > 0) && (k % FRAME == 0);
        if (k >= VD + 1) begin
            p    = k - VD - 1;
            pc   = p % TC;
            pr   = (p / TC) % TR;
            ehs  = !(pc >= 656 && pc <= 751);
            evs  = !(pr >= 8 && pr <= 9);
            eact = (pc < 640) && (pr < 6);
            if (eact) begin
                er = rgb_r(k - 1);
                eg = rgb_g(k - 1);
                eb = rgb_b(k - 1);
`ifdef VGA_TIMING_BORDER_EN
                if (pc == 0 || pc == 639 || pr == 0 || pr == 5) begin
                    er = 4'hF;
                    eg = 4'hF;
                    eb = 4'hF;
                end
`endif
            end
        end
        chk("column_count", 32'(column_count), 32'(k % TC));
        chk("row_count", 32'(row_count), 32'((k / TC) % TR));
        chk("frame_start", 32'(frame_start), 32'(efs));
        chk("out_Hsync", 32'(out_Hsync), 32'(ehs));
        chk("out_Vsync", 32'(out_Vsync), 32'(evs));
        chk("out_active", 32'(out_active), 32'(eact));
        chk("out_Red", 32'(out_Red), 32'(er));
        chk("out_Green", 32'(out_Green), 32'(eg));
        chk("out_Blue", 32'(out_Blue), 32'(eb));
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic run_cycle(input logic en);
        enable   = en;
        in_Red   = rgb_r(k);
        in_Green = rgb_g(k);
        in_Blue  = rgb_b(k);
        #1;
        check_all();
        @(posedge clock);
        if (en && reset_n) k++;
        @(negedge clock);
    endtask

    initial begin
        int start;
        int n;

        // Reset held with enable low.
        #2 reset_n = 1'b0;
        @(negedge clock);
        k = 0;
        repeat (3) run_cycle(1'b0);

        // Release with enable high: one full frame plus the next frame's first line.
        reset_n = 1'b1;
        repeat (FRAME + 1000) run_cycle(1'b1);

        // Pseudo-random stalls across two frames.
        start = k;
        n = 0;
        while ((k - start) < 2 * FRAME && n < 40000) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            run_cycle(lfsr[0] | lfsr[1]);
            n++;
        end
        chk("stall_budget", 32'((k - start) >= 2 * FRAME), 32'd1);

        // Seek counts (300,5) and pulse reset mid-cycle.
        n = 0;
        while (!((k % TC) == 300 && ((k / TC) % TR) == 5) && n < 20000) begin
            run_cycle(1'b1);
            n++;
        end
        chk("seek_budget", 32'(((k % TC) == 300) && (((k / TC) % TR) == 5)), 32'd1);
        enable = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        k = 0;
        check_all();
        @(negedge clock);
        repeat (2) run_cycle(1'b0);
        reset_n = 1'b1;
        repeat (2000) run_cycle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates VGA raster timing: pixel column/row counters, active-low Hsync/Vsync with front/back porches, an active-video flag and a frame-start pulse. It drives the sync inputs of the Pong game logic and blanks the returned RGB outside the visible area. Sync is delayed to stay aligned with the game logic's pipelined colour.

## Interface
Parameters:
- TOTAL_COLS, 800, pixels per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- H_FRONT_PORCH, 16, pixels between the end of active video and the Hsync pulse
- H_BACK_PORCH, 48, pixels between the end of the Hsync pulse and the end of the line
- V_FRONT_PORCH, 10, lines between the end of active video and the Vsync pulse
- V_BACK_PORCH, 33, lines between the end of the Vsync pulse and the end of the frame
- VIDEO_DELAY, 2, cycles by which in_Red/Green/Blue lag the counts they belong to (range 0–7)

Ports:
- clock  in  1  pixel clock
- reset_n  in  1  reset; asynchronous assert, active-low
- enable  in  1  advances the raster by one pixel per cycle while high
- in_Red, in_Green, in_Blue  in  4 each  colour from the game logic
- column_count  out  10  current pixel column, 0..TOTAL_COLS-1
- row_count  out  10  current line, 0..TOTAL_ROWS-1
- frame_start  out  1  single-cycle pulse on frame wrap
- out_Hsync, out_Vsync  out  1 each  active-low sync, aligned with out RGB
- out_active  out  1  high when out RGB is in the visible area
- out_Red, out_Green, out_Blue  out  4 each  blanked colour

## Operation
- column_count and row_count are registered.
  - With enable high, column_count increments each cycle and wraps TOTAL_COLS-1 → 0.
  - On that wrap, row_count increments and wraps TOTAL_ROWS-1 → 0.
- Raw per-count terms, derived from the current counts:
  - h_sync_raw is low for ACTIVE_COLS+H_FRONT_PORCH ≤ col ≤ TOTAL_COLS-H_BACK_PORCH-1. With the defaults this is columns 656..751, 96 pixels.
  - v_sync_raw is low for rows 490..491 with the defaults, using the same formula.
  - act_raw = (col < ACTIVE_COLS) && (row < ACTIVE_ROWS).
- Delay line: h_sync_raw, v_sync_raw and act_raw pass through a VIDEO_DELAY-deep register shift line. VIDEO_DELAY=0 means no stages.
- Output register: out_Hsync, out_Vsync and out_active take the delay-line tail. out RGB = tail_active ? in RGB : 4'h0.
- frame_start is registered. It is high for exactly one cycle, the cycle in which the counts read (0,0) after a wrap from (TOTAL_COLS-1, TOTAL_ROWS-1).
- Enable low:
  - counters, delay line, output registers and RGB outputs all hold;
  - frame_start is forced low.

  Because everything holds together, alignment survives any stall pattern.
- Reset (asynchronous, any time including mid-frame):
  - counts 0, frame_start 0;
  - out_Hsync 1, out_Vsync 1, out_active 0, out RGB 0;
  - all delay-line stages loaded with sync=1 and active=0.
- Reset does not produce a frame_start pulse.
- Counter arithmetic is 10-bit unsigned. Parameters with TOTAL_COLS or TOTAL_ROWS > 1024 are illegal.

## Timing
- Count latency:
  - First enabled cycle after reset release: counts (0,0).
  - (1,0) follows one enabled cycle later.
- Alignment rule: the counts presented at enabled cycle n, together with the in RGB sampled at enabled cycle n+VIDEO_DELAY, appear at the out_* ports after enabled cycle n+VIDEO_DELAY+1.
- Frame period: TOTAL_COLS×TOTAL_ROWS enabled cycles (420000 with the defaults); frame_start repeats at this period.
- out_Hsync and out_Vsync are glitch-free because they come straight from registers.

## Configuration
- Macro VGA_TIMING_BORDER_EN.
- Defined: any visible pixel with col==0, col==ACTIVE_COLS-1, row==0 or row==ACTIVE_ROWS-1 (taken from the delayed position) outputs 4'hF on all three channels, overriding in RGB. This needs the two edge flags carried through the delay line.
- Undefined: no override; out RGB is strictly the blanked in RGB.

## Test plan
- Reset, then reset_n released with enable=1:
  - counts start at (0,0);
  - out_Hsync, out_Vsync =1 and out RGB =0 for the first VIDEO_DELAY+1 cycles;
  - no frame_start pulse.
- Enable held high for one full line, defaults:
  - out_Hsync goes low exactly 656+VIDEO_DELAY+1 cycles after reset release;
  - it stays low 96 cycles;
  - the line repeats every 800 cycles.
- Full frame:
  - out_Vsync is low for exactly 2×800 cycles, starting at line 490;
  - frame_start pulses once per 420000 cycles, coinciding with counts (0,0).
- in RGB held at 4'hA:
  - out RGB = 4'hA only when out_active=1 (columns 0..639, rows 0..479 delayed);
  - 4'h0 elsewhere;
  - out_active pulses 640 cycles wide per visible line.
- Enable toggled pseudo-randomly over 2 frames:
  - out sequence equals the enable-high sequence with stalled cycles removed;
  - frame_start is never high while enable=0.
- reset_n pulsed low at counts (300,200):
  - all outputs go to reset values immediately, without waiting for a clock edge;
  - after release, timing restarts from (0,0).
- With VGA_TIMING_BORDER_EN defined and in RGB =0: out RGB =4'hF exactly on rows 0 and 479 and columns 0 and 639 of the visible area.
